// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 serial-port emulator.
package ltc2308_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StReady,
    StShift
  } state_e;

  localparam int unsigned RESULT_W = 12;
  localparam int unsigned CFG_W    = 6;
  localparam int unsigned N_CH     = 8;

  // Bit positions inside the config word {S/D,O/S,S1,S0,UNI,SLP}
  localparam int unsigned SD  = 5;
  localparam int unsigned OS  = 4;
  localparam int unsigned S1  = 3;
  localparam int unsigned S0  = 2;
  localparam int unsigned UNI = 1;
  localparam int unsigned SLP = 0;

  // CH0, single-ended, unipolar
  localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

endpackage

// File: rtl/ltc2308_result_calc.sv
// Combinational channel mux and output coding (unipolar/bipolar, single/differential).
module ltc2308_result_calc
  import ltc2308_pkg::*;
(
  input  logic [CFG_W-1:0]         cfg,
  input  logic [RESULT_W*N_CH-1:0] sample_bus,
  output logic [RESULT_W-1:0]      result
);

  logic [RESULT_W-1:0]      ch [N_CH];
  logic [2:0]               sel_idx;
  logic [2:0]               neg_idx;
  logic signed [RESULT_W:0] diff;
  logic                     unused_slp;

  assign unused_slp = cfg[SLP];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch[i] = sample_bus[RESULT_W*i +: RESULT_W];
    end
  end

  // {S1,S0,O/S} is both the single-ended channel and the positive input 2k+O/S
  assign sel_idx = {cfg[S1], cfg[S0], cfg[OS]};
  assign neg_idx = {cfg[S1], cfg[S0], ~cfg[OS]};
  assign diff    = $signed({1'b0, ch[sel_idx]}) - $signed({1'b0, ch[neg_idx]});

  always_comb begin
    result = '0;
    if (cfg[SD]) begin
      result = cfg[UNI] ? ch[sel_idx] : (ch[sel_idx] ^ 12'h800);
    end else if (cfg[UNI]) begin
      result = diff[RESULT_W] ? '0 : diff[RESULT_W-1:0];
    end else if (diff > 13'sd2047) begin
      result = 12'h7FF;
    end else if (diff < -13'sd2048) begin
      result = 12'h800;
    end else begin
      result = diff[RESULT_W-1:0];
    end
  end

endmodule

// File: rtl/ltc2308_emulator.sv
// Device-side LTC2308 serial-port emulator; pins are oversampled with clk.
// Define LTC2308_EMU_ERRCHK_EN to build the sticky protocol checker (proto_err).
module ltc2308_emulator
  import ltc2308_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 80,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     convst,
  input  logic                     sck,
  input  logic                     sdi,
  output logic                     sdo,
  input  logic [RESULT_W*N_CH-1:0] sample_bus,
  output logic [CFG_W-1:0]         cfg_word,
  output logic                     cfg_valid,
  output logic                     busy,
  output logic                     proto_err
);

  localparam int unsigned CNT_W = $clog2(CONV_CYCLES);

  logic [2:0]          sync_q [SYNC_STAGES];
  logic [2:0]          pins_s;
  logic [1:0]          pins_q;
  logic                convst_s, sck_s, sdi_s;
  logic                convst_rise, sck_rise, sck_fall;
  logic                start_conv;

  state_e              state;
  logic [RESULT_W-1:0] shreg;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          rise_cnt;
  logic [3:0]          fall_cnt;
  logic [CFG_W-1:0]    pending;
  logic [RESULT_W-1:0] result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      pins_q <= '0;
    end else begin
      sync_q[0] <= {convst, sck, sdi};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      pins_q <= pins_s[2:1];
    end
  end

  assign pins_s      = sync_q[SYNC_STAGES-1];
  assign convst_s    = pins_s[2];
  assign sck_s       = pins_s[1];
  assign sdi_s       = pins_s[0];
  assign convst_rise = convst_s & ~pins_q[1];
  assign sck_rise    = sck_s & ~pins_q[0];
  assign sck_fall    = ~sck_s & pins_q[0];

  // A CONVST rise restarts conversion from any state except CONVERT itself
  assign start_conv  = convst_rise && (state != StConvert);

  ltc2308_result_calc u_result_calc (
    .cfg        (cfg_word),
    .sample_bus (sample_bus),
    .result     (result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      sdo       <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      rise_cnt  <= '0;
      fall_cnt  <= '0;
      pending   <= '0;
      cfg_word  <= CFG_RESET;
      cfg_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      if (start_conv) begin
        state <= StConvert;
        shreg <= result;
        cnt   <= CNT_W'(CONV_CYCLES - 1);
        busy  <= 1'b1;
        sdo   <= 1'b0;
      end else begin
        unique case (state)
          StIdle: ;
          StConvert: begin
            if (cnt == '0) begin
              state <= StReady;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          StReady: begin
            if (!convst_s) begin
              state    <= StShift;
              sdo      <= shreg[RESULT_W-1];
              rise_cnt <= '0;
              fall_cnt <= '0;
            end
          end
          StShift: begin
            if (sck_rise && rise_cnt < 3'd6) begin
              pending  <= {pending[CFG_W-2:0], sdi_s};
              rise_cnt <= rise_cnt + 1'b1;
            end else if (sck_fall) begin
              if (fall_cnt == 4'd11) begin
                sdo       <= 1'b0;
                cfg_word  <= pending;
                cfg_valid <= 1'b1;
                state     <= StIdle;
              end else begin
                sdo      <= shreg[RESULT_W-2];
                shreg    <= shreg << 1;
                fall_cnt <= fall_cnt + 1'b1;
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

`ifdef LTC2308_EMU_ERRCHK_EN
  logic err_hit;

  // CONVST can only be high in SHIFT via a rise, so the level check covers both SHIFT cases
  assign err_hit = ((state == StConvert) && (convst_rise || sck_rise || sck_fall)) ||
                   ((state == StShift) && convst_s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (err_hit) begin
      proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_ltc2308_emulator.sv
// Randomized bench for ltc2308_emulator against a behavioural ADC model.
module tb_ltc2308_emulator;

  localparam int CONV = 80;
  localparam logic [5:0] CFG_RST = 6'b100010;
`ifdef LTC2308_EMU_ERRCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, convst, sck, sdi;
  logic        sdo, cfg_valid, busy, proto_err;
  logic [95:0] sample_bus;
  logic [5:0]  cfg_word;

  logic [11:0] samp [8];
  logic [5:0]  model_cfg;
  int          n_total = 0;
  int          n_bad = 0;
  int          n_valid = 0;

  ltc2308_emulator dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .convst     (convst),
    .sck        (sck),
    .sdi        (sdi),
    .sdo        (sdo),
    .sample_bus (sample_bus),
    .cfg_word   (cfg_word),
    .cfg_valid  (cfg_valid),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  always #10 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) sample_bus[12*i +: 12] = samp[i];
  end

  always @(negedge clk) if (cfg_valid) n_valid++;

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC behaviour from first principles: pick channels, subtract, clamp, code
  function automatic logic [11:0] ref_result(input logic [5:0] c);
    int pos, neg, a;
    pos = 4 * int'(c[3]) + 2 * int'(c[2]) + int'(c[4]);
    neg = 4 * int'(c[3]) + 2 * int'(c[2]) + (1 - int'(c[4]));
    if (c[5]) begin
      a = int'(samp[pos]);
      if (!c[1]) a = (a + 2048) % 4096;
      return 12'(a);
    end
    a = int'(samp[pos]) - int'(samp[neg]);
    if (c[1]) begin
      if (a < 0) a = 0;
    end else begin
      if (a > 2047) a = 2047;
      if (a < -2048) a = -2048;
    end
    return 12'(a);
  endfunction

  task automatic run_conversion(input bit chk_len, input bit poke_sck);
    int t = 0;
    int n = 0;
    convst = 1'b1;
    while (busy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("busy_rise", busy, 1'b1);
    while (busy === 1'b1 && n < 400) begin
      n++;
      if (n == 4) convst = 1'b0;
      if (poke_sck && (n == 15 || n == 25)) sck = 1'b1;
      if (poke_sck && (n == 20 || n == 30)) sck = 1'b0;
      @(negedge clk);
    end
    convst = 1'b0;
    sck    = 1'b0;
    if (chk_len) check_eq("busy_len", n, CONV);
    check_eq("busy_fall", busy, 1'b0);
  endtask

  task automatic shift_bits(input logic [5:0] wr, input int nbits, output logic [11:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 6) ? wr[5-i] : 1'b0;
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      got[11-i] = sdo;
      sck = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic finish_frame(input logic [5:0] wr);
    logic [11:0] exp, got;
    int v0;
    exp = ref_result(model_cfg);
    v0  = n_valid;
    shift_bits(wr, 12, got);
    check_eq("sdo_word", got, exp);
    check_eq("cfg_word", cfg_word, wr);
    check_eq("cfg_valid_cnt", n_valid - v0, 1);
    check_eq("sdo_idle", sdo, 1'b0);
    model_cfg = wr;
  endtask

  task automatic do_frame(input logic [5:0] wr);
    run_conversion(1'b1, 1'b0);
    finish_frame(wr);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n   = 1'b1;
    model_cfg = CFG_RST;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [11:0] junk;
    int v0;
    reset_n = 1'b0;
    convst  = 1'b0;
    sck     = 1'b0;
    sdi     = 1'b0;
    for (int i = 0; i < 8; i++) samp[i] = 12'($urandom_range(0, 4095));
    @(negedge clk);
    apply_reset();

    check_eq("rst_sdo", sdo, 1'b0);
    check_eq("rst_cfg", cfg_word, CFG_RST);
    check_eq("rst_valid", cfg_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", proto_err, 1'b0);

    // Directed chain: each frame writes the config used by the next one
    samp[0] = 12'h5A3;
    do_frame(6'b110010);
    samp[1] = 12'h123;
    do_frame(6'b111110);
    samp[7] = 12'hABC;
    do_frame(6'b100100);
    samp[2] = 12'h000;
    do_frame(6'b000010);
    samp[0] = 12'd100;
    samp[1] = 12'd300;
    do_frame(6'b000000);
    do_frame(6'b000000);
    samp[0] = 12'd4095;
    samp[1] = 12'd0;
    do_frame(6'b100010);
    check_eq("err_clean", proto_err, 1'b0);

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) samp[i] = $urandom_range(0, 1) ? 12'hFFF : 12'h000;
        else samp[i] = 12'($urandom_range(0, 4095));
      end
      do_frame(6'($urandom));
    end
    check_eq("err_random", proto_err, 1'b0);

    // Abort: CONVST rise after 5 SCK rises leaves the config untouched
    run_conversion(1'b1, 1'b0);
    shift_bits(6'($urandom), 5, junk);
    v0 = n_valid;
    run_conversion(1'b1, 1'b0);
    check_eq("abort_cfg", cfg_word, model_cfg);
    check_eq("abort_valid", n_valid - v0, 0);
    check_eq("abort_err", proto_err, EXP_ERR);
    finish_frame(6'($urandom));

    // SCK activity during conversion
    apply_reset();
    check_eq("err_cleared", proto_err, 1'b0);
    for (int i = 0; i < 8; i++) samp[i] = 12'($urandom_range(0, 4095));
    run_conversion(1'b1, 1'b1);
    finish_frame(6'b101110);
    check_eq("sck_conv_err", proto_err, EXP_ERR);

    // Reset in the middle of a frame
    run_conversion(1'b1, 1'b0);
    shift_bits(6'b011111, 4, junk);
    sck = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_sdo", sdo, 1'b0);
    check_eq("mid_rst_cfg", cfg_word, CFG_RST);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_valid", cfg_valid, 1'b0);
    check_eq("mid_rst_err", proto_err, 1'b0);
    sck = 1'b0;
    repeat (3) @(negedge clk);
    reset_n   = 1'b1;
    model_cfg = CFG_RST;
    repeat (3) @(negedge clk);
    samp[0] = 12'($urandom_range(1, 4095));
    do_frame(6'($urandom));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ltc2308_emulator.md
# ltc2308_emulator

Synthesizable emulator of the LTC2308 ADC serial port, used as the device-side end of the 4-wire CONVST/SCK/SDI/SDO link. It sits on GPIO or in loopback next to the Qsys ADC controller and lets the controller be exercised without the real converter. It samples the master's pins with the system clock, returns programmable 12-bit channel values, and captures the 6-bit configuration word that selects the next conversion.

## Interface
Parameters:
- CONV_CYCLES, 80: clk cycles of emulated conversion time (1.6 µs at 50 MHz); minimum 4.
- SYNC_STAGES, 2: synchronizer flops on CONVST/SCK/SDI; minimum 2.

Ports:
- clk  input  1  system clock (50 MHz)
- reset_n  input  1  asynchronous active-low reset
- convst  input  1  CONVST from master
- sck  input  1  serial clock from master
- sdi  input  1  configuration data from master
- sdo  output  1  conversion data to master
- sample_bus  input  96  channel values, ch n at [12n+11:12n], unsigned 0..4095
- cfg_word  output  6  last accepted config {S/D,O/S,S1,S0,UNI,SLP}
- cfg_valid  output  1  one-cycle pulse when cfg_word updates
- busy  output  1  high in CONVERT
- proto_err  output  1  sticky protocol-error flag; cleared only by reset

## Operation
- States: IDLE, CONVERT, READY, SHIFT. All transitions use synchronized, edge-detected pins.
- IDLE: CONVST rise → CONVERT. Compute the result from sample_bus and the active config. Load the 12-bit shift register. Load the conversion counter with CONV_CYCLES-1.
- CONVERT: count down to 0, then go to READY. CONVST rise and SCK edges are ignored here.
- READY: CONVST low → SHIFT, sdo = result[11]. CONVST rise → new conversion (re-enter CONVERT, result reloaded).
- SHIFT:
  - SCK rise: the first 6 rises shift SDI MSB-first into the pending config.
  - SCK fall: sdo takes the next bit down.
  - After the 12th fall: sdo=0, cfg_word ← pending, cfg_valid pulses, go to IDLE.
  - CONVST rise in SHIFT aborts the frame: config is not updated, go to CONVERT.
- Channel select, single-ended (S/D=1): ch = {S1,S0,O/S}, value a = ch value.
- Differential (S/D=0): k = {S1,S0}, a = ch[2k+O/S] − ch[2k+!O/S], computed in 13-bit signed.
- Output coding:
  - UNI=1, single-ended: result = a.
  - UNI=1, differential: clamp a to 0..4095.
  - UNI=0, single-ended: result = a ^ 12'h800 (offset binary to two's complement).
  - UNI=0, differential: saturate a to −2048..2047.
- SLP is stored and reported only; it has no other effect.
- Reset values: state=IDLE, sdo=0, cfg_word=6'b100010 (CH0, single-ended, unipolar), cfg_valid=0, busy=0, proto_err=0.

## Timing
- Pin-to-internal latency is SYNC_STAGES+1 clk. sdo changes SYNC_STAGES+1 clk after an SCK fall or CONVST fall.
- SCK high and low phases must each be at least SYNC_STAGES+2 clk. At defaults, SCK max is 6.25 MHz at 50 MHz.
- busy rises 1 clk after CONVST rise is detected and stays high exactly CONV_CYCLES clk.
- The first frame after reset returns CH0 under the reset config. A config written in frame N applies to conversion N+1.
- If reset_n is asserted mid-frame, all outputs return to their reset values immediately (async) and any partial config is lost.

## Configuration
- LTC2308_EMU_ERRCHK_EN defined: proto_err is set by any of:
  - an SCK edge or CONVST rise during CONVERT;
  - CONVST rise during SHIFT;
  - CONVST high while in SHIFT after its falling edge.
- Not defined: proto_err is tied 0 and the checker logic is absent. State behaviour is identical in both builds.

## Structure
- Package ltc2308_pkg holds:
  - the state enum;
  - the cfg field index constants (SD=5, OS=4, S1=3, S0=2, UNI=1, SLP=0);
  - RESULT_W=12, CFG_W=6, N_CH=8, and the reset config constant.
- One sub-module: ltc2308_result_calc, combinational. Inputs are cfg and sample_bus; output is the 12-bit coded result. It holds the mux and the clamp/saturate arithmetic.

## Test plan
- Reset, ch0=12'h5A3, one frame with SDI=6'b110010 → sdo bits 0x5A3 MSB-first; cfg_word=6'b110010 with one cfg_valid pulse; busy high exactly 80 clk.
- Next frame: ch1=12'h123, config {S/D=1,O/S=1,S1=0,S0=0,UNI=1} → sdo 0x123. Repeat for ch7 with {1,1,1,1} → ch7 value.
- Bipolar single-ended: ch2=12'h000, UNI=0 → sdo 12'h800.
- Differential pair 0, O/S=0:
  - ch0=100, ch1=300, UNI=1 → sdo 0 (clamped);
  - same values, UNI=0 → 12'hF38 (−200);
  - ch0=4095, ch1=0, UNI=0 → 12'h7FF (saturated).
- Abort and error checks:
  - CONVST rise after the 5th SCK of a frame → cfg_word unchanged, no cfg_valid, new conversion starts; proto_err=1 with LTC2308_EMU_ERRCHK_EN, 0 without.
  - SCK toggled during CONVERT → proto_err=1 (EN build) and the result is still correct.
- reset_n pulsed low mid-SHIFT → sdo=0, cfg_word=6'b100010, state IDLE; the next frame returns CH0.
